// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency WIDTH+2 cycles (1 cycle for divide-by-zero/overflow); holds the pipeline via stall.
module rv32m_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic             op_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;

    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    // op[0] clear selects the signed variants (DIV/REM), op[1] set selects remainder
    assign is_signed = ~op[0];
    assign sign_a    = is_signed & dividend[WIDTH-1];
    assign sign_b    = is_signed & divisor[WIDTH-1];
    assign dvd_abs   = sign_a ? -dividend : dividend;
    assign dvs_abs   = sign_b ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign overflow  = is_signed && (dividend == MIN_NEG) && (divisor == '1);

    // Trial subtraction is one bit wider so its MSB is the borrow (negative result)
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};

    assign busy  = (state == CALC) || (state == FIX);
    assign stall = busy | (start & (state == IDLE));
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (div_zero || overflow) ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        state_nxt = FIX;
                    end
                end
                FIX:     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result    <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_rem_q  <= op[1];
                        neg_quo_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        dvs_q     <= dvs_abs;
                        quo_q     <= dvd_abs;
                        rem_q     <= '0;
                        if (div_zero) begin
                            result <= op[1] ? dividend : '1;
                        end else if (overflow) begin
                            result <= op[1] ? '0 : MIN_NEG;
                        end else begin
                            cnt_q <= CNT_INIT;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    if (op_rem_q) begin
                        result <= neg_rem_q ? -rem_q : rem_q;
                    end else begin
                        result <= neg_quo_q ? -quo_q : quo_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Self-checking bench for rv32m_div_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_rv32m_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] last_exp = '0;

    rv32m_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V division semantics straight from the ISA rules
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o == 2'b01) return a / b;
        if (o == 2'b11) return a % b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          cyc;
        logic        got;
        logic        stall_ok;
        exp     = ref_model(o, a, b);
        exp_lat = (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
        @(posedge clk);
        #1 start = 1'b1; op = o; dividend = a; divisor = b;
        #1;
        chk({tag, "_stall_c0"}, stall, 1);
        chk({tag, "_done_c0"}, done, 0);
        chk({tag, "_hold"}, result, last_exp);
        cyc      = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        while (!got && cyc < 60) begin
            @(posedge clk);
            // Mid-op input churn must not disturb the operation in flight
            #1 start = 1'($urandom); op = 2'($urandom); dividend = $urandom; divisor = $urandom;
            cyc++;
            #1;
            if (done) got = 1'b1;
            else if (!stall) stall_ok = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_stall_at_done"}, stall, 0);
        chk({tag, "_stall_held"}, stall_ok, 1);
        if (got) last_exp = exp;
    endtask

    task automatic flush_test();
        int pulses;
        @(posedge clk);
        #1 start = 1'b1; op = 2'b01; dividend = $urandom; divisor = 32'd5;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1 start = 1'b0; flush = (c == 10);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_result_kept", result, last_exp);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2 if (done) pulses++;
        end
        chk("flush_no_done", pulses, 0);

        @(posedge clk);
        #1 start = 1'b1; flush = 1'b1; op = 2'b00; dividend = 32'd100; divisor = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        #1;
        chk("flush_start_busy", busy, 0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2 if (done || busy) pulses++;
        end
        chk("flush_start_ignored", pulses, 0);
    endtask

    task automatic reset_test();
        @(posedge clk);
        #1 start = 1'b1; op = 2'b00; dividend = 32'd1000; divisor = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1 start = 1'b0; reset = (c == 20);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        last_exp = '0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);

        run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(2'b00, 32'd1234, 32'd0, "div_by0");
        run_op(2'b11, 32'd1234, 32'd0, "remu_by0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
        flush_test();
        run_op(2'b01, 32'd999, 32'd10, "after_flush");
        reset_test();
        run_op(2'b00, 32'h7FFF_FFFF, 32'd1, "after_reset");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
                2: rb = 32'd0;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: rb = 32'($signed($urandom_range(0, 20)) - 10);
                default: ra = -$urandom_range(0, 5000);
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
